// File: rtl/program_counter_stack_if.sv
// ============================================================================
// program_counter_stack_if : sequencer <-> program counter strobes and status
// Rev 1.0
// ============================================================================
`default_nettype none

interface program_counter_stack_if #(
  parameter int ADDR_W      = 4,
  parameter int STACK_DEPTH = 4
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic              inc;
  logic              jump;
  logic              jump_cond;
  logic              flag;
  logic              call;
  logic              ret;
  logic              out;
  logic              clr_err;
  logic [ADDR_W-1:0] pc;
  logic [SP_W-1:0]   sp;
  logic              stack_full;
  logic              stack_empty;
  logic              err_overflow;
  logic              err_underflow;
  logic              wrapped;

  modport master (
    output inc, jump, jump_cond, flag, call, ret, out, clr_err,
    input  pc, sp, stack_full, stack_empty, err_overflow, err_underflow, wrapped
  );

  modport slave (
    input  inc, jump, jump_cond, flag, call, ret, out, clr_err,
    output pc, sp, stack_full, stack_empty, err_overflow, err_underflow, wrapped
  );
endinterface

`default_nettype wire

// File: rtl/program_counter_stack.sv
// ============================================================================
// program_counter_stack : program counter with jump/call/ret and return stack
// Rev 1.0
// ============================================================================
`default_nettype none

module program_counter_stack #(
  parameter int ADDR_W      = 4,
  parameter int BUS_W       = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0
) (
  input  wire                         clk,
  input  wire                         rst,
  program_counter_stack_if.slave      ctrl,
  inout  wire  [BUS_W-1:0]            bus
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic [ADDR_W-1:0] count_q, count_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_unf_q, err_unf_d;
  logic              wrapped_q, wrapped_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic [ADDR_W-1:0] bus_addr;
  logic [ADDR_W-1:0] top_entry;
  logic [SP_W-1:0]   sp_m1;
  logic              push_en;
  logic              ovf_set;
  logic              unf_set;
  logic              bus_unused;

  // While out=1 the bus carries our own count, so jump/call load it back unchanged.
  assign bus        = ctrl.out ? BUS_W'(count_q) : {BUS_W{1'bz}};
  assign bus_addr   = bus[ADDR_W-1:0];
  assign bus_unused = ^bus;
  assign sp_m1      = sp_q - 1'b1;

  always_comb begin
    top_entry = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_m1 == SP_W'(i)) top_entry = stack_q[i];
    end
  end

  always_comb begin
    count_d   = count_q;
    sp_d      = sp_q;
    push_en   = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    wrapped_d = 1'b0;
    if (ctrl.ret) begin
      if (sp_q != '0) begin
        count_d = top_entry;
        sp_d    = sp_m1;
      end else begin
        unf_set = 1'b1;
      end
    end else if (ctrl.call) begin
      if (sp_q != SP_W'(STACK_DEPTH)) begin
        push_en = 1'b1;
        count_d = bus_addr;
        sp_d    = sp_q + 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (ctrl.jump || (ctrl.jump_cond && ctrl.flag)) begin
      count_d = bus_addr;
    end else if (ctrl.inc) begin
      count_d   = count_q + 1'b1;
      wrapped_d = &count_q;
    end
  end

  // A new error in the same cycle as clr_err takes precedence over the clear.
  assign err_ovf_d = ovf_set | (err_ovf_q & ~ctrl.clr_err);
  assign err_unf_d = unf_set | (err_unf_q & ~ctrl.clr_err);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= ADDR_W'(RESET_ADDR);
      sp_q      <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      sp_q      <= sp_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
      wrapped_q <= wrapped_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (rst && push_en && (sp_q == SP_W'(i))) stack_q[i] <= count_q;
    end
  end

  assign ctrl.pc            = count_q;
  assign ctrl.sp            = sp_q;
  assign ctrl.stack_full    = (sp_q == SP_W'(STACK_DEPTH));
  assign ctrl.stack_empty   = (sp_q == '0);
  assign ctrl.err_overflow  = err_ovf_q;
  assign ctrl.err_underflow = err_unf_q;
  assign ctrl.wrapped       = wrapped_q;

endmodule

`default_nettype wire

// File: tb/tb_program_counter_stack.sv
// ============================================================================
// tb_program_counter_stack : directed self-checking bench for program_counter_stack
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_program_counter_stack;

  logic       clk;
  logic       rst;
  logic       drv_en;
  logic [7:0] drv_val;
  wire  [7:0] bus;
  int         checks;
  int         errors;

  program_counter_stack_if #(.ADDR_W(4), .STACK_DEPTH(4)) ifc ();

  program_counter_stack #(
    .ADDR_W(4), .BUS_W(8), .STACK_DEPTH(4), .RESET_ADDR(0)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (ifc.slave),
    .bus  (bus)
  );

  assign bus = drv_en ? drv_val : 8'bz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.inc = 0; ifc.jump = 0; ifc.jump_cond = 0; ifc.flag = 0;
    ifc.call = 0; ifc.ret = 0; ifc.out = 0; ifc.clr_err = 0;
    drv_en = 0; drv_val = 8'h00;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    tick(); tick();
    checks++; if (ifc.pc !== 4'd0) begin errors++; $display("FAIL reset_pc actual=%0h expected=0", ifc.pc); end
    checks++; if (ifc.sp !== 3'd0) begin errors++; $display("FAIL reset_sp actual=%0d expected=0", ifc.sp); end
    checks++; if (ifc.stack_empty !== 1'b1 || ifc.stack_full !== 1'b0) begin errors++; $display("FAIL reset_empty_full actual=%b%b expected=10", ifc.stack_empty, ifc.stack_full); end
    checks++; if ({ifc.err_overflow, ifc.err_underflow, ifc.wrapped} !== 3'b000) begin errors++; $display("FAIL reset_flags actual=%b expected=000", {ifc.err_overflow, ifc.err_underflow, ifc.wrapped}); end
    rst = 1;
    tick();
  endtask

  task automatic test_inc_wrap();
    ifc.inc = 1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++; if (ifc.pc !== 4'(i % 16)) begin errors++; $display("FAIL inc_pc step=%0d actual=%0h expected=%0h", i, ifc.pc, i % 16); end
      checks++; if (ifc.wrapped !== (i == 16)) begin errors++; $display("FAIL inc_wrapped step=%0d actual=%b expected=%b", i, ifc.wrapped, i == 16); end
    end
    ifc.inc = 0;
    tick();
    checks++; if (ifc.wrapped !== 1'b0 || ifc.pc !== 4'd0) begin errors++; $display("FAIL wrap_pulse_end actual=%b/%0h expected=0/0", ifc.wrapped, ifc.pc); end
    ifc.inc = 1;
    tick(); tick();
    ifc.inc = 0;
    checks++; if (ifc.pc !== 4'd2) begin errors++; $display("FAIL inc_pre_reset actual=%0h expected=2", ifc.pc); end
    #3 rst = 0;
    #1;
    checks++; if (ifc.pc !== 4'd0) begin errors++; $display("FAIL async_reset_pc actual=%0h expected=0", ifc.pc); end
    rst = 1;
    tick();
  endtask

  task automatic test_bus_jump();
    drv_en = 1; drv_val = 8'hA7; ifc.jump = 1;
    tick();
    checks++; if (ifc.pc !== 4'h7) begin errors++; $display("FAIL jump_a7 actual=%0h expected=7", ifc.pc); end
    drv_val = 8'h05;
    tick();
    ifc.jump = 0; drv_en = 0; ifc.out = 1;
    #1;
    checks++; if (bus !== 8'h05) begin errors++; $display("FAIL bus_drive actual=%0h expected=05", bus); end
    ifc.out = 0; drv_en = 1; drv_val = 8'h3A;
    #1;
    checks++; if (bus !== 8'h3A) begin errors++; $display("FAIL bus_release actual=%0h expected=3a", bus); end
    ifc.jump = 1;
    tick();
    checks++; if (ifc.pc !== 4'hA) begin errors++; $display("FAIL jump_3a actual=%0h expected=a", ifc.pc); end
    drv_en = 0; ifc.out = 1;
    tick();
    checks++; if (ifc.pc !== 4'hA) begin errors++; $display("FAIL jump_self actual=%0h expected=a", ifc.pc); end
    idle();
  endtask

  task automatic test_jump_cond();
    drv_en = 1; drv_val = 8'h09; ifc.jump_cond = 1; ifc.inc = 1; ifc.flag = 0;
    tick();
    checks++; if (ifc.pc !== 4'hB) begin errors++; $display("FAIL jcond_not_taken actual=%0h expected=b", ifc.pc); end
    ifc.flag = 1;
    tick();
    checks++; if (ifc.pc !== 4'h9) begin errors++; $display("FAIL jcond_taken actual=%0h expected=9", ifc.pc); end
    idle();
    drv_en = 1; drv_val = 8'h04; ifc.jump = 1; ifc.inc = 1;
    tick();
    checks++; if (ifc.pc !== 4'h4) begin errors++; $display("FAIL jump_over_inc actual=%0h expected=4", ifc.pc); end
    idle();
  endtask

  task automatic test_call_ret();
    drv_en = 1; drv_val = 8'h03; ifc.jump = 1;
    tick();
    ifc.jump = 0; ifc.call = 1; drv_val = 8'h08;
    tick();
    checks++; if (ifc.pc !== 4'h8 || ifc.sp !== 3'd1) begin errors++; $display("FAIL call1 actual=%0h/%0d expected=8/1", ifc.pc, ifc.sp); end
    drv_val = 8'h0C;
    tick();
    checks++; if (ifc.pc !== 4'hC || ifc.sp !== 3'd2) begin errors++; $display("FAIL call2 actual=%0h/%0d expected=c/2", ifc.pc, ifc.sp); end
    idle(); ifc.ret = 1;
    tick();
    checks++; if (ifc.pc !== 4'h8 || ifc.sp !== 3'd1) begin errors++; $display("FAIL ret1 actual=%0h/%0d expected=8/1", ifc.pc, ifc.sp); end
    tick();
    checks++; if (ifc.pc !== 4'h3 || ifc.sp !== 3'd0 || ifc.stack_empty !== 1'b1) begin errors++; $display("FAIL ret2 actual=%0h/%0d/%b expected=3/0/1", ifc.pc, ifc.sp, ifc.stack_empty); end
    idle();
  endtask

  task automatic test_overflow_underflow();
    ifc.call = 1; drv_en = 1;
    for (int i = 1; i <= 4; i++) begin
      drv_val = 8'(i);
      tick();
    end
    checks++; if (ifc.stack_full !== 1'b1 || ifc.sp !== 3'd4 || ifc.pc !== 4'h4) begin errors++; $display("FAIL fill actual=%b/%0d/%0h expected=1/4/4", ifc.stack_full, ifc.sp, ifc.pc); end
    drv_val = 8'h09;
    tick();
    checks++; if (ifc.pc !== 4'h4 || ifc.sp !== 3'd4 || ifc.err_overflow !== 1'b1) begin errors++; $display("FAIL overflow actual=%0h/%0d/%b expected=4/4/1", ifc.pc, ifc.sp, ifc.err_overflow); end
    idle(); ifc.ret = 1;
    tick();
    checks++; if (ifc.pc !== 4'h3) begin errors++; $display("FAIL pop1 actual=%0h expected=3", ifc.pc); end
    tick();
    checks++; if (ifc.pc !== 4'h2) begin errors++; $display("FAIL pop2 actual=%0h expected=2", ifc.pc); end
    tick();
    checks++; if (ifc.pc !== 4'h1) begin errors++; $display("FAIL pop3 actual=%0h expected=1", ifc.pc); end
    tick();
    checks++; if (ifc.pc !== 4'h3 || ifc.sp !== 3'd0 || ifc.err_underflow !== 1'b0) begin errors++; $display("FAIL pop4 actual=%0h/%0d/%b expected=3/0/0", ifc.pc, ifc.sp, ifc.err_underflow); end
    tick();
    checks++; if (ifc.pc !== 4'h3 || ifc.sp !== 3'd0 || ifc.err_underflow !== 1'b1) begin errors++; $display("FAIL underflow actual=%0h/%0d/%b expected=3/0/1", ifc.pc, ifc.sp, ifc.err_underflow); end
    ifc.ret = 0;
    tick();
    checks++; if (ifc.err_overflow !== 1'b1 || ifc.err_underflow !== 1'b1) begin errors++; $display("FAIL sticky actual=%b%b expected=11", ifc.err_overflow, ifc.err_underflow); end
    ifc.clr_err = 1;
    tick();
    checks++; if (ifc.err_overflow !== 1'b0 || ifc.err_underflow !== 1'b0) begin errors++; $display("FAIL clr_err actual=%b%b expected=00", ifc.err_overflow, ifc.err_underflow); end
    idle();
  endtask

  task automatic test_priority();
    drv_en = 1; drv_val = 8'h06; ifc.call = 1;
    tick();
    drv_val = 8'h0E; ifc.ret = 1; ifc.jump = 1; ifc.inc = 1;
    tick();
    checks++; if (ifc.pc !== 4'h3 || ifc.sp !== 3'd0 || ifc.err_overflow !== 1'b0) begin errors++; $display("FAIL prio_pop actual=%0h/%0d/%b expected=3/0/0", ifc.pc, ifc.sp, ifc.err_overflow); end
    idle(); ifc.out = 1; ifc.call = 1;
    tick();
    checks++; if (ifc.pc !== 4'h3 || ifc.sp !== 3'd1) begin errors++; $display("FAIL call_self actual=%0h/%0d expected=3/1", ifc.pc, ifc.sp); end
    idle(); drv_en = 1; drv_val = 8'h0D; ifc.ret = 1;
    tick();
    checks++; if (ifc.pc !== 4'h3 || ifc.sp !== 3'd0) begin errors++; $display("FAIL ret_self actual=%0h/%0d expected=3/0", ifc.pc, ifc.sp); end
    idle(); drv_en = 1; ifc.call = 1;
    for (int i = 1; i <= 4; i++) begin
      drv_val = 8'(i + 8);
      tick();
    end
    ifc.clr_err = 1;
    tick();
    checks++; if (ifc.err_overflow !== 1'b1 || ifc.pc !== 4'hC) begin errors++; $display("FAIL clr_vs_overflow actual=%b/%0h expected=1/c", ifc.err_overflow, ifc.pc); end
    idle();
    tick();
    checks++; if (ifc.err_overflow !== 1'b1 || ifc.sp !== 3'd4) begin errors++; $display("FAIL hold actual=%b/%0d expected=1/4", ifc.err_overflow, ifc.sp); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_inc_wrap();
    test_bus_jump();
    test_jump_cond();
    test_call_ret();
    test_overflow_underflow();
    test_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
- Parametrised next-generation program counter for the 8-bit CPU.
- Holds the instruction address, increments, and performs unconditional jumps, conditional jumps and subroutine call/return through an internal LIFO return-address stack.
- Drives its count onto the shared tri-state bus on request and loads jump or call targets from the same bus.
- Sits between the control sequencer (strobes) and the memory address register (via bus).

Parameters:
- ADDR_W, 4, width of the program counter in bits; 1 to BUS_W.
- BUS_W, 8, width of the shared data bus.
- STACK_DEPTH, 4, number of return-address entries; minimum 1.
- RESET_ADDR, 0, count value loaded at reset; must fit in ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- inc  input  1  increment count.
- jump  input  1  unconditional load of count from bus.
- jump_cond  input  1  conditional load of count from bus, qualified by flag.
- flag  input  1  condition flag from the flags register.
- call  input  1  push count onto stack, then load count from bus.
- ret  input  1  pop top of stack into count.
- out  input  1  drive count onto bus.
- clr_err  input  1  synchronous clear of sticky error flags.
- bus  inout  BUS_W  shared bus; driven only while out=1, otherwise high-Z.
- pc  output  ADDR_W  current count, for debug and display.
- sp  output  clog2(STACK_DEPTH+1)  number of occupied stack entries.
- stack_full  output  1  sp == STACK_DEPTH.
- stack_empty  output  1  sp == 0.
- err_overflow  output  1  sticky; a call was attempted while full.
- err_underflow  output  1  sticky; a ret was attempted while empty.
- wrapped  output  1  one-cycle pulse; the increment rolled over from all-ones to 0.

Behaviour:
- Reset (rst low, asynchronous, immediate):
  - count = RESET_ADDR and sp = 0.
  - err_overflow, err_underflow and wrapped = 0.
  - Stack contents are don't-care.
  - Reset asserted mid-operation aborts any pending push or pop; no partial update is visible.
- Strobe priority on each rising edge, highest first: ret, call, jump, taken jump_cond, inc. Exactly one action executes per cycle; lower-priority strobes that cycle are ignored.
- ret:
  - If sp>0: count <= stack[sp-1], sp <= sp-1.
  - If sp=0: count holds, sp holds, err_underflow <= 1.
- call:
  - If sp<STACK_DEPTH: stack[sp] <= count (pushed as-is; the sequencer has already incremented past the call instruction), count <= bus[ADDR_W-1:0], sp <= sp+1.
  - If full: no push, count holds, err_overflow <= 1.
- jump: count <= bus[ADDR_W-1:0]. Upper bus bits are ignored.
- jump_cond:
  - If flag=1, acts exactly as jump.
  - If flag=0, it is treated as absent and the next priority (inc) is evaluated.
- inc: count <= count+1 modulo 2^ADDR_W. wrapped = 1 for the cycle following a rollover from all-ones to 0; otherwise 0.
- No strobe: all state holds.
- Bus drive:
  - bus = zero-extended count whenever out=1, combinationally.
  - bus = high-Z otherwise.
  - out together with jump or call in the same cycle loads the PC's own value: count holds, and call still pushes.
- Error flags:
  - Sticky until clr_err=1 at a rising edge.
  - If clr_err and a new error occur in the same cycle, the new error wins (flag = 1).
- Outputs pc, sp, stack_full and stack_empty reflect registered state with zero latency after the edge.
- Stack storage is registers; no memory macro.

Test Plan:
- Reset/inc wrap (ADDR_W=4): release rst, pulse inc 16 times -> pc steps 0..15 then 0; wrapped high for exactly one cycle after the 15->0 edge; rst low mid-count -> pc=0 immediately.
- Bus drive/jump: bus driven 0xA7 with jump=1 -> pc=7. out=1 with pc=5 -> bus reads 0x05; out=0 -> bus high-Z.
- Conditional jump: bus=0x09, jump_cond=1, inc=1, flag=0 -> pc increments by 1. Same stimulus with flag=1 -> pc=9.
- Call/return nesting (DEPTH=4):
  - From pc=3, call to 8, then call to 12 -> sp=2.
  - ret -> pc=8, sp=1; ret -> pc=3, sp=0, stack_empty=1.
- Overflow/underflow: 4 calls -> stack_full=1; fifth call -> pc unchanged, sp=4, err_overflow=1. Pop all 4, then ret -> err_underflow=1, pc unchanged. clr_err -> both flags 0.
- Priority/simultaneous: ret+call+jump+inc together with sp=1 -> pop only (sp=0, pc=stack top). clr_err together with an overflowing call -> err_overflow remains 1.
